// File: rtl/seanet_rbtrx_rpn_extract.sv
// Registered AXIS passthrough that extracts the SEATL RPN/rpara fields of each packet
// and presents them as one meta word per packet on a separate valid/ready channel.
module seanet_rbtrx_rpn_extract #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  output logic [47:0]           m_meta_data,
  output logic                  m_meta_valid,
  input  logic                  m_meta_ready
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam logic [15:0] BEAT_BYTES = 16'(BYTES);
  localparam logic [14:0] RPN_ADJ    = 15'd22;
  localparam logic [14:0] RPARA_ADJ  = 15'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic                  r_rst_done;

  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [USER_WIDTH-1:0] r_tuser;

  logic [14:0]           r_cnt;
  logic [14:0]           r_rpn_off;
  logic [14:0]           r_rpara_off;
  logic                  r_present;
  logic [31:0]           r_rpn;
  logic [3:0]            r_rpn_have;
  logic [7:0]            r_rpara;
  logic                  r_rpara_have;

  logic [47:0]           r_meta_data;
  logic                  r_meta_valid;

  logic                  w_meta_block;
  logic                  w_s_fire;
  logic                  w_first;
  logic                  w_present;
  logic [14:0]           w_rpn_off;
  logic [14:0]           w_rpara_off;
  logic [15:0]           w_base;
  logic [15:0]           w_cnt_sum;
  logic [14:0]           w_cnt_nx;
  logic [31:0]           w_rpn_nx;
  logic [3:0]            w_rpn_have_nx;
  logic [7:0]            w_rpara_nx;
  logic                  w_rpara_have_nx;
  logic                  w_rpn_ok;
  logic [47:0]           w_meta_nx;

  // A tlast beat may only be taken once the meta slot is free or being popped this cycle.
  assign w_meta_block  = s_axis_tlast && r_meta_valid && !m_meta_ready;
  assign s_axis_tready = r_rst_done && (m_axis_tready || !r_tvalid) && !w_meta_block;
  assign w_s_fire      = s_axis_tvalid && s_axis_tready;

  // Any beat outside BODY starts a packet; its tuser carries the SEATL offset and flag.
  assign w_first     = (r_state != ST_BODY);
  assign w_present   = w_first ? s_axis_tuser[8] : r_present;
  assign w_rpn_off   = w_first ? ({7'd0, s_axis_tuser[7:0]} + RPN_ADJ)   : r_rpn_off;
  assign w_rpara_off = w_first ? ({7'd0, s_axis_tuser[7:0]} + RPARA_ADJ) : r_rpara_off;

  assign w_base    = w_first ? '0 : {1'b0, r_cnt};
  assign w_cnt_sum = w_base + BEAT_BYTES;
  assign w_cnt_nx  = w_cnt_sum[15] ? 15'h7FFF : w_cnt_sum[14:0];

  always_comb begin
    logic [15:0] lane_idx;
    lane_idx        = '0;
    w_rpn_nx        = w_first ? '0   : r_rpn;
    w_rpn_have_nx   = w_first ? '0   : r_rpn_have;
    w_rpara_nx      = w_first ? '0   : r_rpara;
    w_rpara_have_nx = w_first ? 1'b0 : r_rpara_have;
    for (int unsigned i = 0; i < BYTES; i++) begin
      lane_idx = w_base + 16'(i);
      if (s_axis_tkeep[i]) begin
        for (int unsigned j = 0; j < 4; j++) begin
          if (lane_idx == ({1'b0, w_rpn_off} + 16'(j))) begin
            w_rpn_nx[8*(3-j) +: 8] = s_axis_tdata[8*i +: 8];
            w_rpn_have_nx[j]       = 1'b1;
          end
        end
        if (lane_idx == {1'b0, w_rpara_off}) begin
          w_rpara_nx      = s_axis_tdata[8*i +: 8];
          w_rpara_have_nx = 1'b1;
        end
      end
    end
  end

  assign w_rpn_ok  = &w_rpn_have_nx;
  assign w_meta_nx = w_present
                   ? {w_rpn_nx, w_rpara_nx, 6'b0, !(w_rpn_ok && w_rpara_have_nx), w_rpn_ok}
                   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= '0;
    end else if (w_s_fire) begin
      r_tdata  <= s_axis_tdata;
      r_tkeep  <= s_axis_tkeep;
      r_tvalid <= 1'b1;
      r_tlast  <= s_axis_tlast;
      r_tuser  <= s_axis_tuser;
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_rpn_off    <= '0;
      r_rpara_off  <= '0;
      r_present    <= 1'b0;
      r_rpn        <= '0;
      r_rpn_have   <= '0;
      r_rpara      <= '0;
      r_rpara_have <= 1'b0;
    end else if (w_s_fire) begin
      r_cnt        <= w_cnt_nx;
      r_rpn_off    <= w_rpn_off;
      r_rpara_off  <= w_rpara_off;
      r_present    <= w_present;
      r_rpn        <= w_rpn_nx;
      r_rpn_have   <= w_rpn_have_nx;
      r_rpara      <= w_rpara_nx;
      r_rpara_have <= w_rpara_have_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_meta_data  <= '0;
      r_meta_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_s_fire) r_state <= s_axis_tlast ? ST_DONE : ST_BODY;
        end
        ST_BODY: begin
          if (w_s_fire && s_axis_tlast) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (w_s_fire)          r_state <= s_axis_tlast ? ST_DONE : ST_BODY;
          else if (m_meta_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_s_fire && s_axis_tlast) begin
        r_meta_data  <= w_meta_nx;
        r_meta_valid <= 1'b1;
      end else if (m_meta_ready) begin
        r_meta_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign m_meta_data   = r_meta_data;
  assign m_meta_valid  = r_meta_valid;

endmodule

// File: tb/tb_seanet_rbtrx_rpn_extract.sv
// Table-driven scoreboard bench for seanet_rbtrx_rpn_extract (64-bit data path).
module tb_seanet_rbtrx_rpn_extract;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [63:0] user;
  } beat_t;

  typedef struct {
    int          len;
    logic [7:0]  off;
    bit          present;
    logic [31:0] rpn;
    logic [7:0]  rpara;
    logic [47:0] exp_meta;
  } vec_t;

  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] s_axis_tuser = '0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [63:0] m_axis_tuser;
  logic [47:0] m_meta_data;
  logic        m_meta_valid;
  logic        m_meta_ready = 1'b1;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   bp_en     = 1'b0;
  bit   meta_hold = 1'b0;
  bit   mon_en    = 1'b1;

  beat_t       beat_q[$];
  logic [47:0] meta_q[$];
  vec_t        vecs[NV];

  seanet_rbtrx_rpn_extract #(
    .DATA_WIDTH(64),
    .KEEP_WIDTH(8),
    .USER_WIDTH(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_meta_data   (m_meta_data),
    .m_meta_valid  (m_meta_valid),
    .m_meta_ready  (m_meta_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sink-side ready generation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_meta_ready  = meta_hold ? 1'b0 : (bp_en ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Output monitor and scoreboard
  bit          prev_tv, prev_tr, prev_mv, prev_mr;
  bit          new_beat, new_meta;
  logic [47:0] prev_md;
  beat_t       exp_beat;
  logic [47:0] exp_meta;

  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      prev_tv = 0; prev_tr = 0; prev_mv = 0; prev_mr = 0; prev_md = '0;
    end else begin
      new_beat = m_axis_tvalid && (!prev_tv || prev_tr);
      new_meta = m_meta_valid && (!prev_mv || prev_mr);
      if (new_beat && m_axis_tlast) chk("meta_with_tlast", m_meta_valid, 1);
      if (new_meta) chk("tlast_with_meta", new_beat && m_axis_tlast, 1);
      if (prev_mv && !prev_mr) begin
        chk("meta_hold_valid", m_meta_valid, 1);
        chk("meta_hold_data", m_meta_data, prev_md);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_expected", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          exp_beat = beat_q.pop_front();
          chk("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, exp_beat);
        end
      end
      if (m_meta_valid && m_meta_ready) begin
        chk("meta_expected", meta_q.size() != 0, 1);
        if (meta_q.size() != 0) begin
          exp_meta = meta_q.pop_front();
          chk("meta", m_meta_data, exp_meta);
        end
      end
      prev_tv = m_axis_tvalid; prev_tr = m_axis_tready;
      prev_mv = m_meta_valid;  prev_mr = m_meta_ready;
      prev_md = m_meta_data;
    end
  end

  // Called aligned to posedge+1; returns aligned to posedge+1.
  task automatic drive_beat(input beat_t bt, input bit sb);
    bit ok;
    ok = 0;
    s_axis_tdata  = bt.data;
    s_axis_tkeep  = bt.keep;
    s_axis_tlast  = bt.last;
    s_axis_tuser  = bt.user;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("accept", ok, 1);
    if (ok && sb) beat_q.push_back(bt);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_packet(input int idx, input bit stall_test, input bit sb, input int abort_at);
    logic [7:0] pkt[];
    int         len, nbeats, roff, poff;
    beat_t      bt;
    len  = vecs[idx].len;
    pkt  = new[len];
    for (int k = 0; k < len; k++) pkt[k] = 8'(k * 7 + 3);
    poff = int'(vecs[idx].off) + 5;
    roff = int'(vecs[idx].off) + 22;
    if (poff < len) pkt[poff] = vecs[idx].rpara;
    for (int j = 0; j < 4; j++) if (roff + j < len) pkt[roff+j] = vecs[idx].rpn[8*(3-j) +: 8];
    nbeats = (len + 7) / 8;
    if (sb) meta_q.push_back(vecs[idx].exp_meta);
    for (int b = 0; b < nbeats; b++) begin
      if (b == abort_at) return;
      bt.data = '0;
      bt.keep = '0;
      for (int l = 0; l < 8; l++) begin
        if (b * 8 + l < len) begin
          bt.data[8*l +: 8] = pkt[b*8+l];
          bt.keep[l] = 1'b1;
        end else begin
          bt.data[8*l +: 8] = 8'hEE;
        end
      end
      bt.last = (b == nbeats - 1);
      bt.user = {$urandom, $urandom};
      if (b == 0) begin
        bt.user[8]   = vecs[idx].present;
        bt.user[7:0] = vecs[idx].off;
      end
      if (stall_test && bt.last) begin
        s_axis_tdata  = bt.data;
        s_axis_tkeep  = bt.keep;
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = bt.user;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("tlast_stall_tready", s_axis_tready, 0);
          if (k == 0) chk("meta_pending", m_meta_valid, 1);
          @(posedge clk);
          #1;
        end
        meta_hold    = 1'b0;
        m_meta_ready = 1'b1;
      end
      drive_beat(bt, sb);
    end
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    for (int g = 0; g < n; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (beat_q.size() == 0 && meta_q.size() == 0 && !m_axis_tvalid && !m_meta_valid) begin
        done = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("drain", done, 1);
  endtask

  task automatic check_reset_state();
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_meta_valid", m_meta_valid, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_meta_data", m_meta_data, 48'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("tready_before_edge", s_axis_tready, 0);
    @(posedge clk);
    #1;
    chk("tready_after_edge", s_axis_tready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{64,  8'd14,  1'b1, 32'h12345678, 8'hA5, 48'h12345678_A5_01};
    vecs[1]  = '{64,  8'd12,  1'b1, 32'h89ABCDEF, 8'h11, 48'h89ABCDEF_11_01};
    vecs[2]  = '{64,  8'd16,  1'b1, 32'h0BADF00D, 8'h22, 48'h0BADF00D_22_01};
    vecs[3]  = '{36,  8'd14,  1'b1, 32'h12345678, 8'hA5, 48'h00000000_A5_02};
    vecs[4]  = '{40,  8'd14,  1'b0, 32'h12345678, 8'hA5, 48'h00000000_00_00};
    vecs[5]  = '{38,  8'd14,  1'b1, 32'hCAFEF00D, 8'h77, 48'hCAFE0000_77_02};
    vecs[6]  = '{64,  8'd255, 1'b1, 32'h01020304, 8'h99, 48'h00000000_00_02};
    vecs[7]  = '{288, 8'd255, 1'b1, 32'hFEEDC0DE, 8'h66, 48'hFEEDC0DE_66_01};
    vecs[8]  = '{8,   8'd0,   1'b1, 32'h11223344, 8'h5A, 48'h00000000_5A_02};
    vecs[9]  = '{26,  8'd0,   1'b1, 32'h55667788, 8'h3C, 48'h55667788_3C_01};
    vecs[10] = '{1,   8'd0,   1'b0, 32'h99999999, 8'h42, 48'h00000000_00_00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    release_reset();

    for (int i = 0; i < NV; i++) begin
      send_packet(i, 0, 1, -1);
      gap();
    end
    drain();

    bp_en = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send_packet(i, 0, 1, -1);
      gap();
    end
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Meta channel held off across two back-to-back packets
    meta_hold    = 1'b1;
    m_meta_ready = 1'b0;
    send_packet(0, 0, 1, -1);
    send_packet(1, 1, 1, -1);
    drain();

    // Reset in the middle of a packet, then a fresh packet
    mon_en = 1'b0;
    send_packet(3, 0, 0, 3);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    release_reset();
    mon_en = 1'b1;
    send_packet(2, 0, 1, -1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
